// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Serial-to-parallel frame receiver fed by the upstream 5-bit serial shift
// registers. The line idles low; a frame is a start bit (1), WIDTH data bits
// LSB first, an optional even-parity bit, and a stop bit (0). Each good word
// is delivered through a one-entry holding register on a valid/ready port.
//
// Parameters
//   WIDTH      data bits per frame (must be >= 2)
//   PARITY_EN  1: an even-parity bit follows the data, 0: no parity bit
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   asynchronous reset, active low
//   si          in   serial input, one bit per clock
//   dout        out  held word, LSB = first data bit received
//   dout_valid  out  holding register full
//   dout_ready  in   consumer accepts when dout_valid && dout_ready
//   dout_perr   out  parity mismatch on the held word (0 without parity)
//   frame_err   out  one-cycle pulse: stop bit was 1
//   overrun     out  one-cycle pulse: good frame dropped, holding reg full
//   busy        out  high while a frame is being received
// -----------------------------------------------------------------------------
module serial_frame_rx #(
   parameter int WIDTH     = 5,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             si,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             dout_perr,
   output logic             frame_err,
   output logic             overrun,
   output logic             busy
);

   localparam int              CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t             state_r;
   logic [CNT_W-1:0]   cnt_r;
   logic [WIDTH-1:0]   shift_r;
   logic               perr_r;
   logic [WIDTH-1:0]   dout_r;
   logic               dout_valid_r;
   logic               dout_perr_r;
   logic               frame_err_r;
   logic               overrun_r;
   logic               busy_r;
   logic               accept_s;

   // XOR of all data bits; combined with the received parity bit it is 1
   // exactly when the total count of ones is odd, i.e. an even-parity error.
   function automatic logic data_parity(input logic [WIDTH-1:0] d);
      return ^d;
   endfunction

   // Consumer handshake on the holding register
   assign accept_s = dout_valid_r && dout_ready;

   // Frame FSM, holding register and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         cnt_r        <= {CNT_W{1'b0}};
         shift_r      <= {WIDTH{1'b0}};
         perr_r       <= 1'b0;
         dout_r       <= {WIDTH{1'b0}};
         dout_valid_r <= 1'b0;
         dout_perr_r  <= 1'b0;
         frame_err_r  <= 1'b0;
         overrun_r    <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         // Error flags are single-cycle pulses
         frame_err_r <= 1'b0;
         overrun_r   <= 1'b0;

         // An accept empties the holding register; a load in the STOP branch
         // below comes later and therefore wins on the same edge.
         if (accept_s) begin
            dout_valid_r <= 1'b0;
         end else begin
            dout_valid_r <= dout_valid_r;
         end

         case (state_r)
            IDLE: begin
               if (si) begin
                  state_r <= DATA;
                  cnt_r   <= {CNT_W{1'b0}};
                  perr_r  <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end

            DATA: begin
               // Right shift: after WIDTH bits the first bit sits in the LSB
               shift_r <= {si, shift_r[WIDTH-1:1]};
               cnt_r   <= cnt_r + CNT_ONE;
               if (cnt_r == LAST_BIT) begin
                  state_r <= PARITY_EN ? PARITY : STOP;
               end else begin
                  state_r <= DATA;
               end
            end

            PARITY: begin
               perr_r  <= data_parity(shift_r) ^ si;
               state_r <= STOP;
            end

            STOP: begin
               // A 1 here is a framing error, never a new start bit
               state_r <= IDLE;
               busy_r  <= 1'b0;
               if (!si) begin
                  if (!dout_valid_r || dout_ready) begin
                     dout_r       <= shift_r;
                     dout_valid_r <= 1'b1;
                     dout_perr_r  <= PARITY_EN ? perr_r : 1'b0;
                  end else begin
                     overrun_r <= 1'b1;
                  end
               end else begin
                  frame_err_r <= 1'b1;
               end
            end

            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign dout       = dout_r;
   assign dout_valid = dout_valid_r;
   assign dout_perr  = dout_perr_r;
   assign frame_err  = frame_err_r;
   assign overrun    = overrun_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Self-checking bench for serial_frame_rx (WIDTH=5, PARITY_EN=1). The bench
// builds every frame itself, so it knows where each stop bit falls and what
// word, parity result and busy level to expect. A small model of the holding
// register applies the delivery / overrun / accept rules every clock, and all
// outputs are compared one time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic         si;
   logic [W-1:0] dout;
   logic         dout_valid;
   logic         dout_ready;
   logic         dout_perr;
   logic         frame_err;
   logic         overrun;
   logic         busy;

   // Expected output state
   logic [W-1:0] m_dout;
   logic         m_valid;
   logic         m_perr;
   logic         m_ferr;
   logic         m_ovr;
   logic         m_busy;

   int checks = 0;
   int errors = 0;

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   serial_frame_rx #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .si         (si),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_perr  (dout_perr),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   // Single comparison point
   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic check_all();
      check_val("dout",       32'(dout),       32'(m_dout));
      check_val("dout_valid", 32'(dout_valid), 32'(m_valid));
      check_val("dout_perr",  32'(dout_perr),  32'(m_perr));
      check_val("frame_err",  32'(frame_err),  32'(m_ferr));
      check_val("overrun",    32'(overrun),    32'(m_ovr));
      check_val("busy",       32'(busy),       32'(m_busy));
   endtask

   task automatic model_reset();
      m_dout  = '0;
      m_valid = 1'b0;
      m_perr  = 1'b0;
      m_ferr  = 1'b0;
      m_ovr   = 1'b0;
      m_busy  = 1'b0;
   endtask

   // ready pattern: 0 low, 1 high, 2 random, 3 high only on the stop bit
   function automatic logic pick_ready(input int mode, input bit last);
      case (mode)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return 1'($urandom_range(1, 0));
         3:       return last;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: ev 0 = no frame end, 1 = good stop bit, 2 = bad stop bit
   task automatic step(input logic s, input logic r, input int ev,
                       input logic [W-1:0] word, input logic pe, input logic bsy);
      si         = s;
      dout_ready = r;
      @(posedge clk);
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
      if (ev == 1) begin
         if (!m_valid || r) begin
            m_dout  = word;
            m_valid = 1'b1;
            m_perr  = pe;
         end else begin
            m_ovr = 1'b1;
         end
      end else begin
         if (ev == 2) m_ferr = 1'b1;
         if (m_valid && r) m_valid = 1'b0;
      end
      m_busy = bsy;
      #1;
      check_all();
   endtask

   task automatic idle(input int n, input int rmode);
      for (int i = 0; i < n; i++) step(1'b0, pick_ready(rmode, 1'b0), 0, '0, 1'b0, 1'b0);
   endtask

   // Full frame; the parity bit is chosen so that data+parity has an even
   // count of ones, then optionally inverted to create a parity error.
   task automatic send_frame(input logic [W-1:0] data, input logic bad_par,
                             input logic bad_stop, input int rmode);
      logic par;
      par = 1'(($countones(data) % 2) != 0) ^ bad_par;
      step(1'b1, pick_ready(rmode, 1'b0), 0, '0, 1'b0, 1'b1);
      for (int i = 0; i < W; i++) step(data[i], pick_ready(rmode, 1'b0), 0, '0, 1'b0, 1'b1);
      step(par, pick_ready(rmode, 1'b0), 0, '0, 1'b0, 1'b1);
      step(bad_stop, pick_ready(rmode, 1'b1), bad_stop ? 2 : 1, data, bad_par, 1'b0);
   endtask

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [W-1:0] d;
      logic         bp;
      logic         bs;
      int           gap;

      rst        = 1'b0;
      si         = 1'b0;
      dout_ready = 1'b0;
      model_reset();
      #2;
      check_all();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;

      // Idle line after reset
      idle(20, 1);

      // Good frame 10110, parity bit 1
      send_frame(5'b10110, 1'b0, 1'b0, 1);
      idle(2, 1);

      // Same frame with parity bit flipped to 0
      send_frame(5'b10110, 1'b1, 1'b0, 1);
      idle(2, 1);

      // Framing error, then a good frame of 00001
      send_frame(5'b01101, 1'b0, 1'b1, 1);
      idle(1, 1);
      send_frame(5'b00001, 1'b0, 1'b0, 1);
      idle(2, 1);

      // Back-pressure: two back-to-back frames, second overruns
      send_frame(5'b00011, 1'b0, 1'b0, 0);
      send_frame(5'b11100, 1'b0, 1'b0, 0);
      idle(2, 0);
      idle(2, 1);

      // Held word, then ready rises exactly on the next stop-bit edge
      send_frame(5'b10101, 1'b0, 1'b0, 0);
      send_frame(5'b01110, 1'b1, 1'b0, 3);
      idle(2, 0);
      idle(1, 1);

      // Reset during data bit 3 of a frame with a held word present
      send_frame(5'b11001, 1'b0, 1'b0, 0);
      step(1'b1, 1'b0, 0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'($urandom_range(1, 0)), 1'b0, 0, '0, 1'b0, 1'b1);
      rst = 1'b0;
      model_reset();
      #1;
      check_all();
      #1;
      rst = 1'b1;
      idle(2, 1);
      send_frame(5'b01010, 1'b0, 1'b0, 1);
      idle(2, 1);

      // Randomized traffic with random back-pressure
      for (int n = 0; n < 200; n++) begin
         d   = W'($urandom);
         bp  = ($urandom_range(3, 0) == 0);
         bs  = ($urandom_range(5, 0) == 0);
         gap = bs ? int'($urandom_range(2, 1)) : int'($urandom_range(2, 0));
         send_frame(d, bp, bs, 2);
         idle(gap, 2);
      end
      idle(4, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
